// File: rtl/vga_rect_scheduler_pkg.sv
// Shared definitions for the rectangle scheduler: FSM encoding, requester
// indices, default screen geometry and small index helpers.
package vga_rect_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] REQ_GUESS = 2'd0;
    localparam logic [1:0] REQ_FB    = 2'd1;
    localparam logic [1:0] REQ_CLEAR = 2'd2;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // One-hot grant to requester index; an invalid vector maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] onehot);
        logic [1:0] idx;
        case (onehot)
            3'b001:  idx = REQ_GUESS;
            3'b010:  idx = REQ_FB;
            3'b100:  idx = REQ_CLEAR;
            default: idx = REQ_GUESS;
        endcase
        return idx;
    endfunction

    // Requester index to one-hot; index 3 maps to no requester.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] onehot;
        case (idx)
            REQ_GUESS: onehot = 3'b001;
            REQ_FB:    onehot = 3'b010;
            REQ_CLEAR: onehot = 3'b100;
            default:   onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/vga_rect_scheduler_rr_arbiter3.sv
// Three-way round-robin selector: the requester after the last granted one
// has the highest priority. Purely combinational.
module rr_arbiter3
    import vga_rect_scheduler_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [2:0] grant
);

    // Rotate priority so the search starts just after the last winner.
    always_comb begin
        grant = 3'b000;
        case (last_grant)
            REQ_GUESS: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            REQ_FB: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/vga_rect_scheduler.sv
// Arbitrates three rectangle-fill requesters and streams the granted
// rectangle to the VGA adapter one pixel per cycle, clipping off-screen pixels.
module vga_rect_scheduler
    import vga_rect_scheduler_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] rx,
    input  logic [20:0] ry,
    input  logic [11:0] rw,
    input  logic [11:0] rh,
    input  logic [8:0]  rcolour,
    output logic [2:0]  ack,
    output logic [2:0]  done,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  colour_out,
    output logic        plot,
    output logic        busy
);

    // Limits in the widened sum widths so the compare sees carries.
    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

    state_t     state_r, state_next_s;
    logic [1:0] last_grant_r;
    logic [1:0] idx_r;
    logic [7:0] base_x_r;
    logic [6:0] base_y_r;
    logic [3:0] w_r, h_r;
    logic [3:0] dx_r, dy_r;
    logic [3:0] dx_next_s, dy_next_s;

    logic [2:0] grant_s;
    logic [1:0] win_idx_s;
    logic [7:0] sel_x_s;
    logic [6:0] sel_y_s;
    logic [3:0] sel_w_s, sel_h_s;
    logic [2:0] sel_col_s;

    logic       latch_s;
    logic       pix_update_s;
    logic [2:0] ack_next_s, done_next_s;
    logic [7:0] base_x_s;
    logic [6:0] base_y_s;
    logic [2:0] colour_next_s;
    logic [8:0] sum_x_s;
    logic [7:0] sum_y_s;
    logic       onscreen_s;

    rr_arbiter3 u_arb (
        .req        (req),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign win_idx_s = onehot_to_idx(grant_s);

    // Pick the winning requester's rectangle fields.
    always_comb begin
        sel_x_s   = rx[7:0];
        sel_y_s   = ry[6:0];
        sel_w_s   = rw[3:0];
        sel_h_s   = rh[3:0];
        sel_col_s = rcolour[2:0];
        case (win_idx_s)
            REQ_FB: begin
                sel_x_s   = rx[15:8];
                sel_y_s   = ry[13:7];
                sel_w_s   = rw[7:4];
                sel_h_s   = rh[7:4];
                sel_col_s = rcolour[5:3];
            end
            REQ_CLEAR: begin
                sel_x_s   = rx[23:16];
                sel_y_s   = ry[20:14];
                sel_w_s   = rw[11:8];
                sel_h_s   = rh[11:8];
                sel_col_s = rcolour[8:6];
            end
            default: begin
                sel_x_s   = rx[7:0];
                sel_y_s   = ry[6:0];
                sel_w_s   = rw[3:0];
                sel_h_s   = rh[3:0];
                sel_col_s = rcolour[2:0];
            end
        endcase
    end

    // Next-state logic and the pixel that the output registers load next.
    always_comb begin
        state_next_s  = state_r;
        dx_next_s     = dx_r;
        dy_next_s     = dy_r;
        latch_s       = 1'b0;
        pix_update_s  = 1'b0;
        ack_next_s    = 3'b000;
        done_next_s   = 3'b000;
        base_x_s      = base_x_r;
        base_y_s      = base_y_r;
        colour_next_s = colour_out;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 3'b000) begin
                    state_next_s  = ST_DRAW;
                    latch_s       = 1'b1;
                    pix_update_s  = 1'b1;
                    dx_next_s     = 4'd0;
                    dy_next_s     = 4'd0;
                    ack_next_s    = grant_s;
                    base_x_s      = sel_x_s;
                    base_y_s      = sel_y_s;
                    colour_next_s = sel_col_s;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if ((dx_r == w_r) && (dy_r == h_r)) begin
                    state_next_s = ST_DONE;
                    done_next_s  = idx_to_onehot(idx_r);
                end else if (dx_r == w_r) begin
                    pix_update_s = 1'b1;
                    dx_next_s    = 4'd0;
                    dy_next_s    = dy_r + 4'd1;
                end else begin
                    pix_update_s = 1'b1;
                    dx_next_s    = dx_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Widened coordinate sums so a wrap past 255/127 still reads as off-screen.
    always_comb begin
        sum_x_s    = {1'b0, base_x_s} + {5'd0, dx_next_s};
        sum_y_s    = {1'b0, base_y_s} + {4'd0, dy_next_s};
        onscreen_s = (sum_x_s < X_LIMIT) && (sum_y_s < Y_LIMIT);
    end

    // State, latched rectangle, counters and registered plot outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= REQ_CLEAR;
            idx_r        <= REQ_GUESS;
            base_x_r     <= 8'd0;
            base_y_r     <= 7'd0;
            w_r          <= 4'd0;
            h_r          <= 4'd0;
            dx_r         <= 4'd0;
            dy_r         <= 4'd0;
            ack          <= 3'b000;
            done         <= 3'b000;
            plot         <= 1'b0;
            x_out        <= 8'd0;
            y_out        <= 7'd0;
            colour_out   <= 3'd0;
        end else begin
            state_r    <= state_next_s;
            dx_r       <= dx_next_s;
            dy_r       <= dy_next_s;
            ack        <= ack_next_s;
            done       <= done_next_s;
            plot       <= pix_update_s & onscreen_s;
            colour_out <= colour_next_s;
            if (latch_s) begin
                base_x_r     <= sel_x_s;
                base_y_r     <= sel_y_s;
                w_r          <= sel_w_s;
                h_r          <= sel_h_s;
                idx_r        <= win_idx_s;
                last_grant_r <= win_idx_s;
            end
            if (pix_update_s) begin
                x_out <= sum_x_s[7:0];
                y_out <= sum_y_s[6:0];
            end
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Scoreboard bench for vga_rect_scheduler: directed requests push expected
// ack/pixel/done events (with cycle stamps); a monitor pops and compares.
module tb_vga_rect_scheduler;

    localparam int SW = 160;
    localparam int SH = 120;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] rx;
    logic [20:0] ry;
    logic [11:0] rw;
    logic [11:0] rh;
    logic [8:0]  rcolour;
    logic [2:0]  ack;
    logic [2:0]  done;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot;
    logic        busy;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int         cyc;
        logic [2:0] bits;
    } ev_t;

    pix_t exp_pix[$];
    ev_t  exp_ack[$];
    ev_t  exp_done[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    vga_rect_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .rx         (rx),
        .ry         (ry),
        .rw         (rw),
        .rh         (rh),
        .rcolour    (rcolour),
        .ack        (ack),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: cycle n is the interval after the n-th rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Expected events for a rectangle whose request is sampled at the end of
    // cycle 'start'. limit<0 means full rectangle; else pixels 0..limit only.
    function automatic void push_rect(input int start, input int idx, input int x,
                                      input int y, input int w, input int h,
                                      input int col, input int limit);
        int   k;
        pix_t p;
        ev_t  e;
        k = 0;
        e.cyc = start + 1;
        e.bits = 3'(1 << idx);
        exp_ack.push_back(e);
        for (int dy = 0; dy <= h; dy++) begin
            for (int dx = 0; dx <= w; dx++) begin
                if ((limit < 0 || k <= limit) && (x + dx < SW) && (y + dy < SH)) begin
                    p.cyc = start + 1 + k;
                    p.x = 8'(x + dx);
                    p.y = 7'(y + dy);
                    p.c = 3'(col);
                    exp_pix.push_back(p);
                end
                k++;
            end
        end
        if (limit < 0) begin
            e.cyc = start + 1 + k;
            e.bits = 3'(1 << idx);
            exp_done.push_back(e);
        end
    endfunction

    task automatic set_fields(input int idx, input int x, input int y,
                              input int w, input int h, input int col);
        rx[idx*8 +: 8]      = 8'(x);
        ry[idx*7 +: 7]      = 7'(y);
        rw[idx*4 +: 4]      = 4'(w);
        rh[idx*4 +: 4]      = 4'(h);
        rcolour[idx*3 +: 3] = 3'(col);
    endtask

    // Single requester: drive at the current negedge, drop req once acked.
    task automatic issue(input int idx, input int x, input int y, input int w,
                         input int h, input int col, input int limit);
        set_fields(idx, x, y, w, h, col);
        req = 3'(1 << idx);
        push_rect(cyc, idx, x, y, w, h, col, limit);
        @(negedge clk);
        req = 3'b000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
        end
    endtask

    // Monitor: every ack/done/plot the DUT presents must match the queue head.
    initial forever begin
        pix_t p;
        ev_t  e;
        @(negedge clk);
        if (plot) begin
            total++;
            if (exp_pix.size() == 0) begin
                bad++;
                $display("FAIL plot_unexpected: got (%0d,%0d) c=%0d at cycle %0d, expected none",
                         x_out, y_out, colour_out, cyc);
            end else begin
                p = exp_pix.pop_front();
                if (p.cyc != cyc || p.x != x_out || p.y != y_out || p.c != colour_out) begin
                    bad++;
                    $display("FAIL pixel: got (%0d,%0d) c=%0d at cycle %0d, expected (%0d,%0d) c=%0d at cycle %0d",
                             x_out, y_out, colour_out, cyc, p.x, p.y, p.c, p.cyc);
                end
            end
            if (!busy) begin
                bad++;
                $display("FAIL plot_not_busy: got plot=1 busy=0 at cycle %0d, expected busy=1", cyc);
            end
        end
        if (ack != 3'b000) begin
            total++;
            if (exp_ack.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected: got %b at cycle %0d, expected none", ack, cyc);
            end else begin
                e = exp_ack.pop_front();
                if (e.cyc != cyc || e.bits != ack) begin
                    bad++;
                    $display("FAIL ack: got %b at cycle %0d, expected %b at cycle %0d",
                             ack, cyc, e.bits, e.cyc);
                end
            end
        end
        if (done != 3'b000) begin
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got %b at cycle %0d, expected none", done, cyc);
            end else begin
                e = exp_done.pop_front();
                if (e.cyc != cyc || e.bits != done) begin
                    bad++;
                    $display("FAIL done: got %b at cycle %0d, expected %b at cycle %0d",
                             done, cyc, e.bits, e.cyc);
                end
            end
        end
    end

    initial begin
        int n0;
        reset   = 1'b1;
        req     = 3'b000;
        rx      = 24'd0;
        ry      = 21'd0;
        rw      = 12'd0;
        rh      = 12'd0;
        rcolour = 9'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_colour", int'(colour_out), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single 2x2 request
        issue(0, 10, 20, 1, 1, 4, -1);
        wait_idle();
        repeat (2) @(negedge clk);

        // Simultaneous requests after reset: order 0,1,2,0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_fields(0, 1, 2, 0, 0, 1);
        set_fields(1, 3, 4, 0, 0, 2);
        set_fields(2, 5, 6, 0, 0, 3);
        req = 3'b111;
        n0 = cyc;
        push_rect(n0,     0, 1, 2, 0, 0, 1, -1);
        push_rect(n0 + 3, 1, 3, 4, 0, 0, 2, -1);
        push_rect(n0 + 6, 2, 5, 6, 0, 0, 3, -1);
        push_rect(n0 + 9, 0, 1, 2, 0, 0, 1, -1);
        repeat (10) @(negedge clk);
        req = 3'b000;
        wait_idle();
        repeat (2) @(negedge clk);

        // Clipping at the bottom-right corner
        issue(2, 158, 119, 3, 1, 6, -1);
        wait_idle();
        repeat (2) @(negedge clk);

        // Reset on pixel 50 of a 16x16 rectangle
        n0 = cyc;
        issue(0, 20, 30, 15, 15, 2, 50);
        while (cyc < n0 + 51) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Withdrawn request from requester 1 while 0 is drawing
        n0 = cyc;
        issue(0, 40, 50, 1, 1, 5, -1);
        set_fields(1, 60, 70, 0, 0, 7);
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        wait_idle();
        chk("withdraw_idle_cycle", cyc, n0 + 6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("withdraw_stays_idle", int'(busy), 0);
        end

        // Maximum size rectangle
        issue(1, 0, 0, 15, 15, 7, -1);
        wait_idle();
        repeat (3) @(negedge clk);

        chk("pix_queue_empty", exp_pix.size(), 0);
        chk("ack_queue_empty", exp_ack.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rect_scheduler.md
VGA_RECT_SCHEDULER -- requirements
Module: vga_rect_scheduler

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 160: the pixel-column limit; columns >= SCREEN_W are off-screen.
REQ-002 The block SHALL have parameter SCREEN_H, default 120: the pixel-row limit; rows >= SCREEN_H are off-screen.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock (CLOCK_50 domain).
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 3 bits: per-requester draw request (0 = guess pegs, 1 = feedback pegs, 2 = board clear).
REQ-006 The block SHALL have port rx, input, 3x8 bits: the rectangle's top-left column, per requester.
REQ-007 The block SHALL have port ry, input, 3x7 bits: the rectangle's top-left row, per requester.
REQ-008 The block SHALL have port rw, input, 3x4 bits: rectangle width minus 1, per requester (width 1..16).
REQ-009 The block SHALL have port rh, input, 3x4 bits: rectangle height minus 1, per requester (height 1..16).
REQ-010 The block SHALL have port rcolour, input, 3x3 bits: fill colour, per requester.
REQ-011 The block SHALL have port ack, output, 3 bits: 1-cycle pulse when the requester's fields are captured.
REQ-012 The block SHALL have port done, output, 3 bits: 1-cycle pulse after the last pixel of a granted rectangle.
REQ-013 The block SHALL have port x_out, output, 8 bits: the plot column to vga_adapter.
REQ-014 The block SHALL have port y_out, output, 7 bits: the plot row to vga_adapter.
REQ-015 The block SHALL have port colour_out, output, 3 bits: the plot colour to vga_adapter.
REQ-016 The block SHALL have port plot, output, 1 bit: write enable to vga_adapter.
REQ-017 The block SHALL have port busy, output, 1 bit: high in DRAW and DONE.

Function
REQ-018 The FSM SHALL have states IDLE, DRAW and DONE, and SHALL transition IDLE->DRAW, DRAW->DONE and DONE->IDLE.
REQ-019 In IDLE with any req bit high, the block SHALL select a winner round-robin, latch the winner's rx/ry/rw/rh/rcolour and index at the clock edge, and enter DRAW.
REQ-020 Round-robin priority SHALL start at the requester after the last granted one; after reset, requester 0 has highest priority.
REQ-021 ack[winner] SHALL be high for exactly the first DRAW cycle; a requester SHALL hold req and its fields stable until it sees ack.
REQ-022 In DRAW the block SHALL emit one pixel per cycle in raster order (dx 0..w inner, dy 0..h outer) with x_out=x+dx, y_out=y+dy, colour_out=latched colour.
REQ-023 Pixel k of a rectangle SHALL appear in DRAW cycle k, so the first pixel is on the ack cycle and a rectangle takes (w+1)(h+1) cycles.
REQ-024 Coordinate sums SHALL be computed 1 bit wider than the port; when x+dx >= SCREEN_W or y+dy >= SCREEN_H, plot SHALL be 0 for that cycle while the counters still advance.
REQ-025 On the last pixel (dx=w, dy=h), the block SHALL enter DONE; in DONE, done[winner]=1 for 1 cycle and plot=0, then return to IDLE.
REQ-026 The minimum gap between the last pixel of one rectangle and the first pixel of the next SHALL be 2 cycles (DONE, IDLE).
REQ-027 req changes during DRAW/DONE SHALL be ignored; a deasserted, unacked req SHALL be dropped without ack or done.
REQ-028 At most one bit of ack and at most one bit of done SHALL be high in any cycle.
REQ-029 x_out, y_out, colour_out and plot SHALL be registered outputs; plot SHALL be 0 outside DRAW.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL enter IDLE and clear ack, done, plot, busy, x_out, y_out and colour_out to 0, and set the RR pointer so requester 0 wins next.
REQ-031 A reset during DRAW or DONE SHALL abort the rectangle with no done pulse; the requester SHALL re-request.

Structure
REQ-032 A shared package SHALL hold the state encoding, the requester index constants (REQ_GUESS=0, REQ_FB=1, REQ_CLEAR=2) and the SCREEN_W/SCREEN_H defaults.
REQ-033 The round-robin selector SHALL be a sub-module, rr_arbiter3 (inputs: req[2:0] and last grant; output: one-hot grant).

Verification
REQ-034 Single request (reset released, req=001, rect 10,20 w=1 h=1 colour 4): ack[0] on cycle 1; plots (10,20), (11,20), (10,21), (11,21) on cycles 1-4; done[0] on cycle 5.
REQ-035 Simultaneous requests (req=111 held, each 1x1): grant order 0, 1, 2, 0; each done is followed by the next ack 2 cycles later.
REQ-036 Clipping (rect x=158, y=119, w=3, h=1): the block takes 8 cycles with plot high only for (158,119) and (159,119).
REQ-037 Reset mid-draw (16x16 rect, reset on pixel 50): the next cycle has plot=0 and busy=0, and done is never pulsed.
REQ-038 Request withdrawn (req[1] pulsed for 1 cycle while busy on req 0): there is no ack[1]; after done[0] the block idles.
REQ-039 Max size (rect x=0, y=0, w=15, h=15): 256 consecutive plot cycles, with the last pixel at (15,15).
